// File: rtl/fetch_addr_gen_pkg.sv
// Shared widths, defaults and redirect-source encoding for the IF-stage fetch address generator.
package fetch_addr_gen_pkg;

  localparam int ADDR_BUS                = 32;
  localparam int DATA_BUS                = 32;
  localparam int INST_BYTES_DEFAULT      = 4;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;
  localparam logic [ADDR_BUS-1:0] RESET_VECTOR_DEFAULT = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BRANCH,
    REDIR_EXC
  } redir_src_e;

  // Exceptions (and eret) always win over a branch in the same cycle.
  function automatic redir_src_e redir_src(input logic exc, input logic br);
    redir_src_e src;
    src = REDIR_NONE;
    if (exc) begin
      src = REDIR_EXC;
    end else if (br) begin
      src = REDIR_BRANCH;
    end
    return src;
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// In-order FIFO of {pc, stale} for fetch requests in flight; kill_all marks every held entry stale.
module fetch_pc_fifo
  import fetch_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int DEPTH      = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  push_stale,
  input  logic                  pop,
  input  logic                  kill_all,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic                  head_stale,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0]      stale_q, stale_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  push_eff, pop_eff;

  assign full       = (count_q == (PW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign pop_eff    = pop && !empty;
  assign push_eff   = push && (!full || pop_eff);
  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_stale = stale_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_eff);
    rd_ptr_d = rd_ptr_q + PW'(pop_eff);
    count_d  = count_q + (PW+1)'(push_eff) - (PW+1)'(pop_eff);
  end

  // Kill touches every slot; slots without a live entry are rewritten on their next push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stale
    always_comb begin
      stale_d[gi] = stale_q[gi];
      if (kill_all) begin
        stale_d[gi] = 1'b1;
      end
      if (push_eff && (wr_ptr_q == PW'(gi))) begin
        stale_d[gi] = push_stale;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      stale_q  <= stale_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      pc_mem[wr_ptr_q] <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_addr_gen.sv
// IF-stage PC generator: valid/ready fetch requests, several in flight, redirect kill of
// outstanding responses, and in-order PC-tagged delivery of live responses to decode.
module fetch_addr_gen
  import fetch_addr_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = ADDR_BUS,
  parameter int                    DATA_WIDTH      = DATA_BUS,
  parameter int                    INST_BYTES      = INST_BYTES_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = RESET_VECTOR_DEFAULT,
  parameter int                    MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_flag,
  input  logic [ADDR_WIDTH-1:0] exc_addr,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  input  logic [DATA_WIDTH-1:0] resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INST_BYTES - 1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  misalign_q, misalign_d;

  redir_src_e            src;
  logic                  redir, fire, hold, pop;
  logic [ADDR_WIDTH-1:0] raw_target, target;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  head_stale, fifo_full, fifo_empty;

  // Reset blocks issue combinationally so no request leaks out while rst is high.
  assign req_valid    = !rst && !fifo_full;
  assign req_addr     = pc_q;
  assign fire         = req_valid && req_ready;
  assign hold         = req_valid && !req_ready;
  assign misalign_err = misalign_q;
  assign out_pc       = head_pc;
  assign out_inst     = resp_data;
  assign pop          = resp_valid && resp_ready;

  always_comb begin
    src        = redir_src(exc_flag, branch_flag);
    redir      = (src != REDIR_NONE);
    raw_target = (src == REDIR_EXC) ? exc_addr : branch_addr;
    target     = raw_target & ~LOW_MASK;
    misalign_d = redir && ((raw_target & LOW_MASK) != '0);

    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    // A held request must keep its address, so a redirect arriving then is parked.
    if (redir && !hold) begin
      pc_d         = target;
      pend_valid_d = 1'b0;
    end else if (redir) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = target;
    end else if (fire && pend_valid_q) begin
      pc_d         = pend_addr_q;
      pend_valid_d = 1'b0;
    end else if (fire) begin
      pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
    end
  end

  always_comb begin
    resp_ready = 1'b0;
    out_valid  = 1'b0;
    if (!fifo_empty) begin
      if (head_stale) begin
        resp_ready = 1'b1;
      end else begin
        out_valid  = resp_valid;
        resp_ready = out_ready;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      misalign_q   <= misalign_d;
    end
  end

  fetch_pc_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fire),
    .push_pc    (pc_q),
    .push_stale (redir || pend_valid_q),
    .pop        (pop),
    .kill_all   (redir),
    .head_pc    (head_pc),
    .head_stale (head_stale),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  resp_without_request: assert property (@(posedge clk) disable iff (rst) !(resp_valid && fifo_empty));

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Bench for fetch_addr_gen: directed scenarios then random traffic against a queue-based model.
module tb_fetch_addr_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_flag = 1'b0, branch_flag = 1'b0;
  logic [31:0] exc_addr = '0, branch_addr = '0;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0, resp_ready;
  logic [31:0] resp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic        misalign_err;

  fetch_addr_gen dut (
    .clk(clk), .rst(rst),
    .exc_flag(exc_flag), .exc_addr(exc_addr),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        live;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_pend_addr;
  bit          m_pend, m_mis;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'hbfc0_0000;
    m_pend = 0;
    m_mis  = 0;
    m_pend_addr = '0;
    mq.delete();
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic cycle();
    logic        e_rv, e_rr, e_ov;
    logic [31:0] tgt;
    bit          redir, fire, hold;
    if (rst) model_reset();
    if (mq.size() == 0) resp_valid = 1'b0;
    resp_data = (mq.size() > 0) ? mem_word(mq[0].pc) : 32'h0;
    #1;
    e_rv = !rst && (mq.size() < DEPTH);
    if (mq.size() == 0) begin
      e_rr = 0; e_ov = 0;
    end else if (!mq[0].live) begin
      e_rr = 1; e_ov = 0;
    end else begin
      e_rr = out_ready; e_ov = resp_valid;
    end
    chk("req_valid", req_valid, e_rv);
    if (e_rv) chk("req_addr", req_addr, m_pc);
    chk("resp_ready", resp_ready, e_rr);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mem_word(mq[0].pc));
    end
    chk("misalign_err", misalign_err, m_mis);
    @(posedge clk);
    if (!rst) begin
      redir = exc_flag || branch_flag;
      tgt   = exc_flag ? exc_addr : branch_addr;
      fire  = e_rv && req_ready;
      hold  = e_rv && !req_ready;
      if (mq.size() > 0 && resp_valid && e_rr) void'(mq.pop_front());
      if (redir) foreach (mq[i]) mq[i].live = 1'b0;
      if (fire) mq.push_back('{pc: m_pc, live: !(redir || m_pend)});
      m_mis = redir && (tgt[1:0] != 2'b00);
      tgt   = {tgt[31:2], 2'b00};
      if (redir && !hold) begin
        m_pc = tgt; m_pend = 0;
      end else if (redir) begin
        m_pend = 1; m_pend_addr = tgt;
      end else if (fire && m_pend) begin
        m_pc = m_pend_addr; m_pend = 0;
      end else if (fire) begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset held three cycles, then sequential fetch from the reset vector.
    repeat (3) cycle();
    rst = 0; req_ready = 1; out_ready = 1;
    #1 chk("t1_addr0", req_addr, 32'hbfc0_0000); cycle();
    #1 chk("t1_addr1", req_addr, 32'hbfc0_0004); cycle();
    #1 chk("t1_addr2", req_addr, 32'hbfc0_0008); cycle();
    // Fill to four in flight; one response frees a slot.
    #1 chk("t2_valid_3", req_valid, 1'b1); cycle();
    resp_valid = 1;
    #1 chk("t2_full", req_valid, 1'b0);
    chk("t2_out_pc", out_pc, 32'hbfc0_0000); cycle();
    resp_valid = 0; req_ready = 0;
    #1 chk("t2_refill", req_valid, 1'b1); cycle();
    resp_valid = 1; cycle();
    // Exception and branch together: exception wins, two live entries die.
    resp_valid = 0; req_ready = 1;
    exc_flag = 1; exc_addr = 32'hbfc0_0380; branch_flag = 1; branch_addr = 32'h8000_1000;
    cycle();
    exc_flag = 0; branch_flag = 0; req_ready = 0; resp_valid = 1; out_ready = 0;
    #1 chk("t3_addr", req_addr, 32'hbfc0_0380);
    chk("t3_drop_ov0", out_valid, 1'b0); chk("t3_drop_rr0", resp_ready, 1'b1); cycle();
    #1 chk("t3_drop_ov1", out_valid, 1'b0); chk("t3_drop_rr1", resp_ready, 1'b1); cycle();
    cycle();
    resp_valid = 0; out_ready = 1;
    // Branch while the request is held: address stays until accepted.
    branch_flag = 1; branch_addr = 32'h8000_2000; cycle();
    branch_flag = 0;
    #1 chk("t4_held0", req_addr, 32'hbfc0_0380); cycle();
    req_ready = 1;
    #1 chk("t4_held1", req_addr, 32'hbfc0_0380); cycle();
    req_ready = 0; resp_valid = 1;
    #1 chk("t4_target", req_addr, 32'h8000_2000);
    chk("t4_drop", out_valid, 1'b0); cycle();
    resp_valid = 0;
    // Misaligned branch target is aligned down and flagged once.
    req_ready = 1; branch_flag = 1; branch_addr = 32'h8000_1002; cycle();
    branch_flag = 0; req_ready = 0;
    #1 chk("t5_mis_hi", misalign_err, 1'b1); chk("t5_addr", req_addr, 32'h8000_1000); cycle();
    #1 chk("t5_mis_lo", misalign_err, 1'b0);
    resp_valid = 1; cycle();
    resp_valid = 0;
    // Wrap at the top of the address space, then reset with three in flight.
    req_ready = 1; branch_flag = 1; branch_addr = 32'hffff_fff8; cycle();
    branch_flag = 0;
    #1 chk("t6_fff8", req_addr, 32'hffff_fff8); cycle();
    #1 chk("t6_fffc", req_addr, 32'hffff_fffc); cycle();
    req_ready = 0;
    #1 chk("t6_wrap", req_addr, 32'h0000_0000); cycle();
    rst = 1;
    #1 chk("t6_rst_ov", out_valid, 1'b0); chk("t6_rst_rv", req_valid, 1'b0);
    chk("t6_rst_rr", resp_ready, 1'b0); cycle();
    rst = 0; req_ready = 1;
    #1 chk("t6_restart", req_addr, 32'hbfc0_0000); cycle();
    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      req_ready   = ($urandom_range(0, 3) != 0);
      resp_valid  = ($urandom_range(0, 2) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      branch_flag = ($urandom_range(0, 11) == 0);
      exc_flag    = ($urandom_range(0, 23) == 0);
      branch_addr = ($urandom_range(0, 7) == 0) ? 32'hffff_fff8 : $urandom;
      exc_addr    = $urandom;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
